mr_order_gen: RTL and testbench
===============================

// Module: mr_order_gen
// PURPOSE
//  Mean-reversion order generator; consumes the accumulator outputs (mid/EMA, Q32.16).
//  Compares mid against EMA and issues BUY/SELL intents on a valid/ready order interface.
//  Each side has hysteresis, there is a post-fill cooldown, and a net position limit.
//  Sits between the accumulator stage and the order-entry/risk path in pipebomb.
// PARAMETERS
//  Q_W          48      width of Q32.16 mid/ema inputs (pipebomb_pkg::PRICE_Q_W)
//  FRAC_W       16      fractional bits (pipebomb_pkg::PRICE_FRAC_W)
//  THRESH_Q     65536   trigger threshold on |mid-ema|, Q32.16 (1.0 tick)
//  WARMUP_TICKS 16      ticks ignored after ema_valid rises (EMA settling)
//  COOLDOWN_CYC 8       clk cycles idle after each accepted order; 0 = none
//  POS_W        16      signed position counter width
//  MAX_POS      100     |pos| limit, units of QTY
//  QTY          1       fixed order quantity
// PORTS
//  clk        in   1           clock
//  rstn       in   1           asynchronous active-low reset
//  mid_q      in   Q_W         mid price, Q32.16 unsigned
//  ema_q      in   Q_W         EMA of mid, Q32.16 unsigned
//  ema_valid  in   1           sticky: EMA has at least one sample
//  sig_tick   in   1           1-cycle pulse: mid_q/ema_q just updated
//  kill       in   1           risk kill switch, level
//  ord_valid  out  1           order intent valid
//  ord_ready  in   1           downstream accepts order
//  ord_side   out  1           0 = BUY, 1 = SELL
//  ord_price  out  Q_W-FRAC_W  integer limit price
//  ord_qty    out  POS_W       order quantity (= QTY)
//  pos        out  POS_W       signed net position (filled = accepted)
//  halted     out  1           FSM in HALT
// BEHAVIOUR
//  Reset: all outputs 0; FSM = WARMUP; warmup count 0; both side-armed latches = 1.
//  diff = $signed({1'b0,mid_q}) - $signed({1'b0,ema_q}), Q_W+1 bits, no saturation.
//  Triggers:
//   - sell_trig = diff > THRESH_Q, and sell_armed.
//   - buy_trig  = diff < -THRESH_Q, and buy_armed.
//   - Both comparisons strict. Exactly +/-THRESH_Q does not trigger.
//  Hysteresis (updated on every sig_tick, in any state):
//   - Issuing a side clears that side's armed latch.
//   - Latch re-arms when diff crosses back inside THRESH_Q/2 (|diff| < THRESH_Q>>1).
//  Position limit:
//   - BUY suppressed if pos+QTY > MAX_POS; SELL suppressed if pos-QTY < -MAX_POS.
//   - A suppressed trigger leaves the armed latch set.
//  Price:
//   - BUY  = floor(mid) = mid_q[Q_W-1:FRAC_W].
//   - SELL = ceil(mid): floor +1 if any frac bit set.
//   - Integer wrap at all-ones is not protected.
//  FSM:
//   - WARMUP: count sig_tick while ema_valid. After WARMUP_TICKS counted -> ARMED.
//     The tick that completes warmup does not trigger.
//   - ARMED: on sig_tick with a trigger, register side/price/qty -> ISSUE.
//     ord_valid rises the next cycle (1-cycle latency).
//   - ISSUE: ord_valid held high; side/price/qty stable until handshake.
//     Handshake = ord_valid & ord_ready. On handshake, pos += QTY (BUY) or -= QTY (SELL).
//     Then -> COOLDOWN, or -> ARMED if COOLDOWN_CYC == 0. ord_valid drops the cycle after.
//   - COOLDOWN: count COOLDOWN_CYC cycles -> ARMED. Ticks here do not trigger.
//   - HALT: halted=1, no orders. kill=0 -> ARMED; pos and warmup are kept.
//  Kill:
//   - kill=1 in any state except ISSUE -> HALT next cycle.
//   - In ISSUE the order is never withdrawn; on handshake -> HALT.
//   - Handshake and kill in the same cycle: fill counts, then HALT.
//  Ticks: a tick while not ARMED is dropped, never queued.
//  A trigger is only taken in ARMED with sig_tick=1.
//  Reset mid-operation: async clear; ord_valid falls immediately; pos=0; in-flight order lost.
// TESTING
//  1 WARMUP_TICKS=4, THRESH=1.0, mid=100.5/ema=98.0 on 5 ticks -> no order on ticks 1-4;
//    tick5 -> ord_valid next cycle, SELL, price 101.
//  2 BUY issued, ord_ready=0 for 10 cycles -> ord_valid/fields stable;
//    ready at cycle 11 -> pos=+1; ARMED after exactly 8 more cycles.
//  3 diff=-1.5 on 3 ticks -> exactly one BUY, price=floor(mid);
//    then diff=-0.25, then -1.5 -> second BUY.
//  4 MAX_POS=2, rearming BUY triggers x3 -> 2 orders, pos=2, third suppressed;
//    next diff=+1.5 -> SELL issued, pos=1.
//  5 kill asserted while ord_valid=1, ready=0 -> order held; ready -> HALT;
//    triggers ignored; kill=0 -> ARMED, next trigger issues.
//  6 rstn low during ISSUE -> ord_valid=0 same cycle, pos=0, WARMUP restarts;
//    diff exactly +1.0 -> no trigger.

Source files
------------

// File: rtl/mr_order_gen.sv
// rtl/mr_order_gen.sv - mean-reversion order generator (mid vs EMA, hysteresis, cooldown, position limit)
module mr_order_gen #(
  parameter int Q_W          = 48,
  parameter int FRAC_W       = 16,
  parameter int THRESH_Q     = 65536,
  parameter int WARMUP_TICKS = 16,
  parameter int COOLDOWN_CYC = 8,
  parameter int POS_W        = 16,
  parameter int MAX_POS      = 100,
  parameter int QTY          = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [Q_W-1:0]           mid_q,
  input  logic [Q_W-1:0]           ema_q,
  input  logic                     ema_valid,
  input  logic                     sig_tick,
  input  logic                     kill,
  output logic                     ord_valid,
  input  logic                     ord_ready,
  output logic                     ord_side,
  output logic [Q_W-FRAC_W-1:0]    ord_price,
  output logic [POS_W-1:0]         ord_qty,
  output logic signed [POS_W-1:0]  pos,
  output logic                     halted
);

  localparam int PW = Q_W - FRAC_W;

  localparam logic [2:0] S_WARMUP   = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_COOLDOWN = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;

  localparam logic signed [Q_W:0]   THR     = (Q_W+1)'(THRESH_Q);
  localparam logic signed [Q_W:0]   HALF    = (Q_W+1)'(THRESH_Q >> 1);
  localparam logic signed [POS_W:0] QTY_X   = (POS_W+1)'(QTY);
  localparam logic signed [POS_W:0] MAX_X   = (POS_W+1)'(MAX_POS);
  localparam logic [POS_W-1:0]      QTY_P   = POS_W'(QTY);
  localparam logic [15:0]           WU_LAST = (WARMUP_TICKS > 0) ? 16'(WARMUP_TICKS - 1) : 16'd0;
  localparam logic [15:0]           CD_LAST = (COOLDOWN_CYC > 0) ? 16'(COOLDOWN_CYC - 1) : 16'd0;

  logic [2:0]  state;
  logic [15:0] wu_cnt;
  logic [15:0] cd_cnt;
  logic        sell_armed;
  logic        buy_armed;

  logic signed [Q_W:0]   diff;
  logic signed [POS_W:0] pos_x;
  logic                  sell_fire;
  logic                  buy_fire;
  logic                  rearm;
  logic                  take;
  logic [PW-1:0]         price_floor;
  logic [PW-1:0]         price_ceil;

  assign diff  = $signed({1'b0, mid_q}) - $signed({1'b0, ema_q});
  assign pos_x = {pos[POS_W-1], pos};
  assign rearm = (diff < HALF) && (diff > -HALF);

  // A trigger blocked by the position limit never fires, so its armed latch survives.
  assign sell_fire = (diff > THR)  && sell_armed && ((pos_x - QTY_X) >= -MAX_X);
  assign buy_fire  = (diff < -THR) && buy_armed  && ((pos_x + QTY_X) <= MAX_X);
  assign take      = (state == S_ARMED) && !kill && sig_tick && (sell_fire || buy_fire);

  assign price_floor = mid_q[Q_W-1:FRAC_W];
  assign price_ceil  = price_floor + PW'(|mid_q[FRAC_W-1:0]);

  assign ord_valid = (state == S_ISSUE);
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_WARMUP;
      wu_cnt     <= '0;
      cd_cnt     <= '0;
      sell_armed <= 1'b1;
      buy_armed  <= 1'b1;
      ord_side   <= 1'b0;
      ord_price  <= '0;
      ord_qty    <= '0;
      pos        <= '0;
    end else begin
      if (sig_tick) begin
        if (rearm) begin
          sell_armed <= 1'b1;
          buy_armed  <= 1'b1;
        end
        if (take && sell_fire) sell_armed <= 1'b0;
        if (take && !sell_fire) buy_armed <= 1'b0;
      end

      case (state)
        S_WARMUP: begin
          if (kill) begin
            state <= S_HALT;
          end else if (sig_tick && ema_valid) begin
            wu_cnt <= wu_cnt + 16'd1;
            if (wu_cnt >= WU_LAST) state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (kill) begin
            state <= S_HALT;
          end else if (take) begin
            ord_side  <= sell_fire;
            ord_price <= sell_fire ? price_ceil : price_floor;
            ord_qty   <= QTY_P;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Kill never withdraws a presented order; it only redirects after the fill.
          if (ord_ready) begin
            pos <= ord_side ? (pos - $signed(QTY_P)) : (pos + $signed(QTY_P));
            cd_cnt <= '0;
            if (kill)                   state <= S_HALT;
            else if (COOLDOWN_CYC == 0) state <= S_ARMED;
            else                        state <= S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (kill) begin
            state <= S_HALT;
          end else if (cd_cnt == CD_LAST) begin
            state <= S_ARMED;
          end else begin
            cd_cnt <= cd_cnt + 16'd1;
          end
        end
        S_HALT: begin
          if (!kill) state <= S_ARMED;
        end
        default: state <= S_WARMUP;
      endcase
    end
  end

endmodule

// File: tb/tb_mr_order_gen.sv
// tb/tb_mr_order_gen.sv - directed self-checking bench for mr_order_gen
module tb_mr_order_gen;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [47:0]        mid_q = '0;
  logic [47:0]        ema_q = '0;
  logic               ema_valid = 1'b0;
  logic               sig_tick = 1'b0;
  logic               kill = 1'b0;
  logic               ord_valid;
  logic               ord_ready = 1'b0;
  logic               ord_side;
  logic [31:0]        ord_price;
  logic [15:0]        ord_qty;
  logic signed [15:0] pos;
  logic               halted;

  int errors = 0;
  int checks = 0;

  mr_order_gen #(
    .WARMUP_TICKS(4),
    .MAX_POS(2)
  ) dut (
    .clk(clk), .rstn(rstn), .mid_q(mid_q), .ema_q(ema_q), .ema_valid(ema_valid),
    .sig_tick(sig_tick), .kill(kill), .ord_valid(ord_valid), .ord_ready(ord_ready),
    .ord_side(ord_side), .ord_price(ord_price), .ord_qty(ord_qty), .pos(pos), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] q(input int ip, input int fr);
    logic [31:0] a;
    logic [31:0] b;
    a = ip;
    b = fr;
    return {a, b[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [47:0] m, input logic [47:0] e);
    mid_q = m;
    ema_q = e;
    sig_tick = 1'b1;
    step();
    sig_tick = 1'b0;
  endtask

  task automatic accept();
    ord_ready = 1'b1;
    step();
    ord_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic warmup(input logic [47:0] m, input logic [47:0] e);
    for (int i = 0; i < 4; i++) begin
      tick(m, e);
      check("warmup_no_order", ord_valid, 0);
    end
  endtask

  logic [47:0] buy_m, buy_e, sell_m, sell_e, zero_q, near_e;

  initial begin
    buy_m  = q(100, 16384);  // 100.25
    buy_e  = q(101, 49152);  // 101.75 -> diff -1.5
    sell_m = q(100, 16384);
    sell_e = q(98, 49152);   // 98.75  -> diff +1.5
    zero_q = q(100, 0);
    near_e = q(100, 32768);  // 100.5  -> diff -0.25

    #2;
    check("reset_valid", ord_valid, 0);
    check("reset_side", ord_side, 0);
    check("reset_price", ord_price, 0);
    check("reset_qty", ord_qty, 0);
    check("reset_pos", pos, 0);
    check("reset_halted", halted, 0);
    step();
    rstn = 1'b1;
    ema_valid = 1'b1;

    // 1: warmup ticks never trigger, fifth tick sells at ceil(100.5)
    warmup(q(100, 32768), q(98, 0));
    tick(q(100, 32768), q(98, 0));
    check("t1_valid", ord_valid, 1);
    check("t1_side", ord_side, 1);
    check("t1_price", ord_price, 101);
    check("t1_qty", ord_qty, 1);
    accept();
    check("t1_pos", pos, -1);
    check("t1_valid_drop", ord_valid, 0);

    // 2: stalled BUY holds, fill, then cooldown of exactly 8 cycles
    do_reset();
    warmup(zero_q, zero_q);
    tick(buy_m, buy_e);
    check("t2_valid", ord_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_hold_valid", ord_valid, 1);
      check("t2_hold_side", ord_side, 0);
      check("t2_hold_price", ord_price, 100);
    end
    accept();
    check("t2_pos", pos, 1);
    check("t2_valid_drop", ord_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick(sell_m, sell_e);
      check("t2_cooldown_drop", ord_valid, 0);
    end
    tick(sell_m, sell_e);
    check("t2_armed_sell", ord_valid, 1);
    check("t2_armed_side", ord_side, 1);
    accept();
    check("t2_pos_back", pos, 0);

    // 3: hysteresis - one BUY per excursion, re-arm inside half threshold
    do_reset();
    warmup(zero_q, zero_q);
    tick(buy_m, buy_e);
    check("t3_buy1", ord_valid, 1);
    check("t3_price", ord_price, 100);
    accept();
    repeat (10) step();
    tick(buy_m, buy_e);
    check("t3_tick2_none", ord_valid, 0);
    tick(buy_m, buy_e);
    check("t3_tick3_none", ord_valid, 0);
    tick(buy_m, near_e);
    check("t3_rearm_none", ord_valid, 0);
    tick(buy_m, buy_e);
    check("t3_buy2", ord_valid, 1);
    check("t3_buy2_side", ord_side, 0);
    accept();
    check("t3_pos", pos, 2);

    // 4: position limit of 2
    do_reset();
    warmup(zero_q, zero_q);
    tick(buy_m, buy_e);
    accept();
    repeat (10) step();
    tick(zero_q, zero_q);
    tick(buy_m, buy_e);
    check("t4_buy2", ord_valid, 1);
    accept();
    check("t4_pos2", pos, 2);
    repeat (10) step();
    tick(zero_q, zero_q);
    tick(buy_m, buy_e);
    check("t4_suppressed", ord_valid, 0);
    check("t4_pos_hold", pos, 2);
    tick(sell_m, sell_e);
    check("t4_sell", ord_valid, 1);
    check("t4_sell_side", ord_side, 1);
    check("t4_sell_price", ord_price, 101);
    accept();
    check("t4_pos1", pos, 1);
    repeat (10) step();
    tick(buy_m, buy_e);
    check("t4_latch_kept", ord_valid, 1);
    accept();
    check("t4_pos_end", pos, 2);

    // 5: kill during a stalled order
    do_reset();
    warmup(zero_q, zero_q);
    tick(buy_m, buy_e);
    kill = 1'b1;
    repeat (3) step();
    check("t5_held", ord_valid, 1);
    check("t5_not_halted", halted, 0);
    accept();
    check("t5_pos", pos, 1);
    check("t5_halted", halted, 1);
    check("t5_valid_drop", ord_valid, 0);
    tick(sell_m, sell_e);
    check("t5_halt_ignore", ord_valid, 0);
    kill = 1'b0;
    step();
    check("t5_unhalted", halted, 0);
    tick(sell_m, sell_e);
    check("t5_resume", ord_valid, 1);
    check("t5_resume_side", ord_side, 1);

    // 6: async reset while an order is presented, then exact-threshold boundary
    #2;
    rstn = 1'b0;
    #1;
    check("t6_valid_async", ord_valid, 0);
    check("t6_pos_async", pos, 0);
    check("t6_price_async", ord_price, 0);
    step();
    rstn = 1'b1;
    warmup(q(101, 0), zero_q);
    tick(q(101, 0), zero_q);
    check("t6_plus_exact", ord_valid, 0);
    tick(zero_q, q(101, 0));
    check("t6_minus_exact", ord_valid, 0);
    tick(q(101, 1), zero_q);
    check("t6_just_over", ord_valid, 1);
    check("t6_price_ceil", ord_price, 102);
    accept();
    check("t6_pos", pos, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
